// File: rtl/turn_signal_input.sv
// ---------------------------------------------------------------------------
// turn_signal_input
//
// Input conditioning for the tail-light sequencer. Each raw switch is
// synchronized and debounced. A free-running divider produces the animation
// step enable. A two-state FSM latches a left/right request on a step and
// holds it unchanged for a whole light sequence.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable clk cycles needed to change a debounced switch (>=2)
//   TICK_DIV         clk cycles per animation step (>=2)
//   SEQ_TICKS        steps a latched command is held
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   sw_left    in   raw left-turn switch (asynchronous, bouncy)
//   sw_right   in   raw right-turn switch (asynchronous, bouncy)
//   sw_hazard  in   raw hazard switch (asynchronous, bouncy)
//   step       out  one-cycle pulse every TICK_DIV cycles (sequencer enable)
//   left       out  latched left request, constant for a whole sequence
//   right      out  latched right request, constant for a whole sequence
//   busy       out  high while a latched command is held
// ---------------------------------------------------------------------------
module turn_signal_input #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TICK_DIV        = 4,
    parameter int SEQ_TICKS       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_left,
    input  logic sw_right,
    input  logic sw_hazard,
    output logic step,
    output logic left,
    output logic right,
    output logic busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = (SEQ_TICKS > 1) ? $clog2(SEQ_TICKS) : 1;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SEQ_LAST  = SW'(SEQ_TICKS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bit order for all per-switch vectors: [0]=left, [1]=right, [2]=hazard.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [DW-1:0] deb_cnt [3];

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] seq_cnt;
    state_t        state;

    logic          req_l;
    logic          req_r;

    assign raw = {sw_hazard, sw_right, sw_left};

    // -----------------------------------------------------------------------
    // Two-flop synchronizer.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the two stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce: a switch must disagree with its debounced value on
    // DEBOUNCE_CYCLES consecutive cycles before the debounced value follows.
    // Any agreement in between restarts the count from zero.
    // -----------------------------------------------------------------------
    // NOTE: the counter array is a handful of flops, not a RAM, so it is
    // reset element by element like any other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= '0;
            for (int i = 0; i < 3; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Free-running step divider, independent of the FSM.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Pure compare on a register, so step is glitch-free and reset forces it
    // low at once through the counter.
    assign step = (tick_cnt == TICK_LAST);

    // -----------------------------------------------------------------------
    // Request decode. Left and right together light both sides, exactly
    // like hazard, which the OR form gives directly.
    // -----------------------------------------------------------------------
    assign req_l = deb[0] | deb[2];
    assign req_r = deb[1] | deb[2];

    // -----------------------------------------------------------------------
    // Sequence FSM. Requests are only sampled on a step in IDLE; in RUN the
    // outputs are frozen so the sequencer sees one command per sequence.
    // Returning to IDLE on a step means the earliest re-latch is the next
    // step, which guarantees one dark step between sequences.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            left    <= 1'b0;
            right   <= 1'b0;
            busy    <= 1'b0;
            seq_cnt <= '0;
        end else if (step) begin
            case (state)
                IDLE: begin
                    if (req_l || req_r) begin
                        state   <= RUN;
                        left    <= req_l;
                        right   <= req_r;
                        busy    <= 1'b1;
                        seq_cnt <= '0;
                    end
                end
                RUN: begin
                    if (seq_cnt == SEQ_LAST) begin
                        state   <= IDLE;
                        left    <= 1'b0;
                        right   <= 1'b0;
                        busy    <= 1'b0;
                        seq_cnt <= '0;
                    end else begin
                        seq_cnt <= seq_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    left    <= 1'b0;
                    right   <= 1'b0;
                    busy    <= 1'b0;
                    seq_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_signal_input.sv
// ---------------------------------------------------------------------------
// tb_turn_signal_input
//
// Self-checking bench for turn_signal_input with DEBOUNCE_CYCLES=4,
// TICK_DIV=3, SEQ_TICKS=4. A reference model tracks the raw switch history
// as a sample window and the sequence as a count of steps since the latch,
// and every cycle the DUT outputs are compared against it. Directed scenarios
// cover reset, clean latch, glitch rejection, decode, mid-run changes and
// bouncing. A randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_turn_signal_input;

    localparam int DEB = 4;
    localparam int TD  = 3;
    localparam int SEQ = 4;

    logic clk;
    logic reset;
    logic sw_left;
    logic sw_right;
    logic sw_hazard;
    logic step;
    logic left;
    logic right;
    logic busy;

    int n_tests;
    int n_fail;

    turn_signal_input #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (TD),
        .SEQ_TICKS      (SEQ)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_left  (sw_left),
        .sw_right (sw_right),
        .sw_hazard(sw_hazard),
        .step     (step),
        .left     (left),
        .right    (right),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Reference model.
    //   hist[k] : raw switch vector sampled k+1 edges ago (index 0 = newest).
    //   A debounced bit follows its input once the last DEB synchronized
    //   samples all disagree with it.
    //   The sequence ends on the SEQ-th step after the latch step.
    // -----------------------------------------------------------------------
    logic [2:0]  hist [0:DEB];
    logic [2:0]  m_deb;
    int unsigned m_edges;
    bit          m_run;
    bit          m_l;
    bit          m_r;
    int          m_steps;

    task automatic model_reset();
        for (int j = 0; j <= DEB; j++) hist[j] = 3'b000;
        m_deb   = 3'b000;
        m_edges = 0;
        m_run   = 0;
        m_l     = 0;
        m_r     = 0;
        m_steps = 0;
    endtask

    function automatic bit model_step();
        return (m_edges % TD) == (TD - 1);
    endfunction

    task automatic model_edge();
        bit rl;
        bit rr;
        bit all_diff;
        rl = m_deb[0] | m_deb[2];
        rr = m_deb[1] | m_deb[2];
        if (model_step()) begin
            if (!m_run) begin
                if (rl || rr) begin
                    m_run   = 1;
                    m_l     = rl;
                    m_r     = rr;
                    m_steps = 0;
                end
            end else begin
                m_steps++;
                if (m_steps == SEQ) begin
                    m_run = 0;
                    m_l   = 0;
                    m_r   = 0;
                end
            end
        end
        // hist[1] is what the second synchronizer flop holds before this edge.
        for (int b = 0; b < 3; b++) begin
            all_diff = 1;
            for (int j = 1; j <= DEB; j++) begin
                if (hist[j][b] == m_deb[b]) all_diff = 0;
            end
            if (all_diff) m_deb[b] = hist[1][b];
        end
        for (int j = DEB; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = {sw_hazard, sw_right, sw_left};
        m_edges++;
    endtask

    // -----------------------------------------------------------------------
    // Checking.
    // -----------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: advance the model on the edge, compare at the negedge.
    task automatic cyc();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        check("step",  32'(step),  32'(model_step()));
        check("left",  32'(left),  32'(m_l));
        check("right", 32'(right), 32'(m_r));
        check("busy",  32'(busy),  32'(m_run));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_sw(input logic l, input logic r, input logic h);
        sw_left   = l;
        sw_right  = r;
        sw_hazard = h;
    endtask

    // Wait (bounded) until busy equals val; returns the cycles taken.
    task automatic wait_busy(input string tag, input logic val, output int n);
        n = 0;
        while (busy !== val && n < 80) begin
            cyc();
            n++;
        end
        check({tag, "_timeout"}, 32'(busy === val), 32'd1);
    endtask

    int  n;
    int  len;
    bit  saw_right;
    bit  saw_both;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        set_sw(0, 0, 0);
        reset = 1'b1;
        model_reset();
        #12;
        check("reset_step",  32'(step),  32'd0);
        check("reset_left",  32'(left),  32'd0);
        check("reset_right", 32'(right), 32'd0);
        check("reset_busy",  32'(busy),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First step after release: high before the 3rd edge.
        cyc();
        check("step_e1", 32'(step), 32'd0);
        cyc();
        check("step_e2", 32'(step), 32'd1);
        run(4);

        // Clean left: latch, hold 12 cycles, one dark step, re-latch.
        set_sw(1, 0, 0);
        wait_busy("left_latch", 1'b1, n);
        check("left_lat_ge6", 32'(n >= 6), 32'd1);
        check("left_val",  32'(left),  32'd1);
        check("right_val", 32'(right), 32'd0);
        wait_busy("left_hold", 1'b0, len);
        check("hold_len", 32'(len), 32'(SEQ * TD));
        wait_busy("left_relatch", 1'b1, len);
        check("gap_len", 32'(len), 32'(TD));
        set_sw(0, 0, 0);
        run(30);

        // Glitch rejection on right.
        saw_right = 0;
        set_sw(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (right === 1'b1 || busy === 1'b1) saw_right = 1;
        end
        set_sw(0, 0, 0);
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (right === 1'b1 || busy === 1'b1) saw_right = 1;
        end
        check("glitch_quiet", 32'(saw_right), 32'd0);

        // Hazard, then left+right together.
        set_sw(0, 0, 1);
        wait_busy("hazard_latch", 1'b1, n);
        check("hazard_lr", 32'({left, right}), 32'b11);
        set_sw(0, 0, 0);
        run(30);
        set_sw(1, 1, 0);
        wait_busy("both_latch", 1'b1, n);
        check("both_lr", 32'({left, right}), 32'b11);
        set_sw(0, 0, 0);
        run(30);

        // Change during RUN: left stays latched, right follows next.
        set_sw(1, 0, 0);
        wait_busy("chg_latch", 1'b1, n);
        run(2);
        set_sw(0, 1, 0);
        saw_both = 0;
        while (busy === 1'b1 && n < 200) begin
            cyc();
            n++;
            if (busy === 1'b1 && left !== 1'b1) saw_both = 1;
        end
        check("chg_left_frozen", 32'(saw_both), 32'd0);
        wait_busy("chg_next", 1'b1, n);
        check("chg_next_lr", 32'({left, right}), 32'b01);
        set_sw(0, 0, 0);
        run(30);

        // Bounce train, then settle high.
        for (int i = 0; i < 10; i++) begin
            set_sw(~sw_left, 0, 0);
            run(2);
        end
        check("bounce_idle", 32'(busy), 32'd0);
        set_sw(1, 0, 0);
        wait_busy("bounce_latch", 1'b1, n);
        check("bounce_lat_ge6", 32'(n >= 6), 32'd1);

        // Reset in the middle of a sequence.
        run(3);
        #2 reset = 1'b1;
        #1;
        check("midrst_step",  32'(step),  32'd0);
        check("midrst_left",  32'(left),  32'd0);
        check("midrst_right", 32'(right), 32'd0);
        check("midrst_busy",  32'(busy),  32'd0);
        model_reset();
        run(2);
        reset = 1'b0;
        set_sw(0, 0, 0);
        run(12);

        // Randomized switch activity: mixes short glitches and long holds.
        for (int seg = 0; seg < 300; seg++) begin
            set_sw(1'($urandom), 1'($urandom), 1'(($urandom % 4) == 0));
            run(($urandom % 3 == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(1, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/turn_signal_input.md
# turn_signal_input

Input conditioning stage for the tail-light sequencer. Synchronizes and debounces the raw left, right and hazard switches, and generates the slow animation step enable. It also latches a turn command that stays stable for one full light sequence. Its `left`, `right` and `step` outputs drive the sequencer's request inputs and clock enable directly.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive stable clk cycles required before a debounced switch state changes; must be ≥2.
- TICK_DIV, default 4: clk cycles per animation step; must be ≥2.
- SEQ_TICKS, default 4: steps a latched command is held (3 lit patterns plus return to off).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock clk.
- sw_left  in  1  raw left-turn switch, asynchronous, may bounce.
- sw_right  in  1  raw right-turn switch, asynchronous, may bounce.
- sw_hazard  in  1  raw hazard switch, asynchronous, may bounce.
- step  out  1  one-cycle pulse every TICK_DIV clk cycles; clock enable for the sequencer.
- left  out  1  latched left request; constant for a whole sequence.
- right  out  1  latched right request; constant for a whole sequence.
- busy  out  1  high while a latched command is being held (state RUN).

## Operation
- **Synchronizer:** each raw switch passes through 2 flops, sync1 then sync2, both reset to 0.
- **Debounce:** one counter per input, width $clog2(DEBOUNCE_CYCLES).
  - While sync2 equals the debounced value, the counter holds 0.
  - While they differ, the counter increments.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, the debounced value takes sync2 and the counter clears.
  - A mismatch that ends early clears the counter; no partial credit carries over.
- **Step generator:** counter runs 0..TICK_DIV-1 and wraps. `step`=1 exactly when the counter equals TICK_DIV-1. The counter is free-running and independent of the FSM.
- **Request decode:**
  - req_l = deb_left | deb_hazard.
  - req_r = deb_right | deb_hazard.
  - deb_left and deb_right both high also decodes as hazard (both sides).
- **FSM states** (2 states, reset to IDLE):
  - IDLE: on a cycle with `step`=1 and (req_l|req_r), load left←req_l, right←req_r, seq_cnt←0, and go to RUN. Otherwise outputs stay 0.
  - RUN: left and right are frozen. Each `step` increments seq_cnt. On a `step` where seq_cnt==SEQ_TICKS-1, clear left and right and return to IDLE.
  - The earliest re-latch is the next `step` after returning to IDLE, so one off-step always separates sequences.
- **Switch changes during RUN** are ignored, but the debounce logic keeps tracking them. The new state takes effect at the next latch opportunity.
- **Reset**, including mid-sequence, immediately forces all of the following to 0:
  - state IDLE; left, right, busy, step;
  - all sync flops, debounced values and counters.

## Timing
- **Input-to-debounced latency:** a clean edge on sw_* reaches deb_* 2+DEBOUNCE_CYCLES clk edges after it is first sampled.
- **Debounced-to-output latency:** 1 to TICK_DIV cycles, until the next `step`. left/right/busy update on the same edge that `step` is high.
- **Sequencer alignment:** left/right are valid and stable on every `step` of a sequence. The sequencer samples them with `step` as its enable.
- **Hold length:** busy stays high for exactly SEQ_TICKS×TICK_DIV cycles per command.
- **Outputs:** all registered, no combinational path from inputs. `step` is derived from a register compare only.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, TICK_DIV=3, SEQ_TICKS=4.
- **Reset:** assert reset mid-run → left=right=busy=step=0 on the same cycle. After release, the first `step` comes on the 3rd clk edge.
- **Clean left:** sw_left=1 held → left=1, right=0, busy=1 latched on the first `step` at or after 6 edges. Held 12 cycles, then off for 1 step, then re-latched.
- **Glitch rejection:** sw_right pulses high for 3 cycles, then low → deb_right never rises, right stays 0, busy stays 0.
- **Hazard and both-switch decode:** (a) sw_hazard=1 gives left=right=1. (b) sw_left=sw_right=1 with sw_hazard=0 also gives left=right=1.
- **Change during RUN:** latch left, then switch to sw_right=1 mid-sequence → left stays 1 until the 4th `step`. The next command latched is right=1, left=0.
- **Bounce train:** sw_left toggles every 2 cycles for 20 cycles, then settles at 1 → no latch during the toggling. Latch on the first `step` ≥6 cycles after settling.
